muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 161 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer that produces HI/LO results.
// Latency: MUL_LAT+1 cycles for multiply, 33 for divide, 1 for divide-by-zero (accept to whilo_out).
// Backpressure: arith_stall holds the execute stage while the unit is busy; start is ignored unless IDLE.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   start, op        request and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b     rs / rt operands
//   flush            abort any operation, no result written
//   arith_stall      combinational hold request to the execute stage
//   busy             high while in MUL or DIV
//   hi_out, lo_out   registered HI/LO results, held between operations
//   whilo_out        one-cycle HI/LO write enable in DONE
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        arith_stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        whilo_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_t      state;
  logic        mul_unsigned;   // latched op[0] for the multiply
  logic [31:0] a_q;            // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0] b_q;            // multiplier, or divisor magnitude
  logic [31:0] rem_q;          // partial remainder
  logic        neg_quo;
  logic        neg_rem;
  logic [5:0]  cnt;

  // Operand magnitudes for a signed divide; DIVU passes operands straight through.
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  assign div_signed = ~op[0];
  assign a_mag = (div_signed && src_a[31]) ? -src_a : src_a;
  assign b_mag = (div_signed && src_b[31]) ? -src_b : src_b;

  // Full 64-bit product; sign- or zero-extension selects MULT vs MULTU.
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  assign ext_a   = {(mul_unsigned ? 32'h0 : {32{a_q[31]}}), a_q};
  assign ext_b   = {(mul_unsigned ? 32'h0 : {32{b_q[31]}}), b_q};
  assign product = ext_a * ext_b;

  // One restoring-divide step. rem_q < divisor, so the shifted remainder is below
  // 2*divisor: bit 32 of the difference is a clean borrow flag.
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        take;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  assign rem_sh  = {rem_q, a_q[31]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign take    = ~rem_sub[32];
  assign rem_nxt = take ? rem_sub[31:0] : rem_sh[31:0];
  assign quo_nxt = {a_q[30:0], take};
  // 0x80000000 / -1 wraps to 0x80000000 here without special handling.
  assign quo_fin = neg_quo ? -quo_nxt : quo_nxt;
  assign rem_fin = neg_rem ? -rem_nxt : rem_nxt;

  assign arith_stall = ((state == IDLE) && start && !flush) || (state == MUL) || (state == DIV);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      busy         <= 1'b0;
      whilo_out    <= 1'b0;
      hi_out       <= 32'h0;
      lo_out       <= 32'h0;
      cnt          <= 6'd0;
      mul_unsigned <= 1'b0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      rem_q        <= 32'h0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
    end else if (flush) begin
      // Abort: no write pulse, results and working registers untouched.
      state     <= IDLE;
      busy      <= 1'b0;
      whilo_out <= 1'b0;
    end else begin
      whilo_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mul_unsigned <= op[0];
            cnt          <= 6'd0;
            rem_q        <= 32'h0;
            if (!op[1]) begin
              state <= MUL;
              busy  <= 1'b1;
              a_q   <= src_a;
              b_q   <= src_b;
            end else if (src_b == 32'h0) begin
              // Divide by zero completes immediately with a fixed result.
              state     <= DONE;
              hi_out    <= src_a;
              lo_out    <= 32'hFFFF_FFFF;
              whilo_out <= 1'b1;
            end else begin
              state   <= DIV;
              busy    <= 1'b1;
              a_q     <= a_mag;
              b_q     <= b_mag;
              neg_quo <= div_signed & (src_a[31] ^ src_b[31]);
              neg_rem <= div_signed & src_a[31];
            end
          end
        end
        MUL: begin
          cnt <= cnt + 6'd1;
          if (cnt == MUL_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            whilo_out <= 1'b1;
            hi_out    <= product[63:32];
            lo_out    <= product[31:0];
          end
        end
        DIV: begin
          cnt   <= cnt + 6'd1;
          rem_q <= rem_nxt;
          a_q   <= quo_nxt;
          if (cnt == DIV_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            whilo_out <= 1'b1;
            hi_out    <= rem_fin;
            lo_out    <= quo_fin;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vector table, corner sequences and random ops against a reference model.
// Two instances: MUL_LAT=2 (main) and MUL_LAT=8 (reset-abort case); both share inputs.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;

  logic        stall2, busy2, whilo2, stall8, busy8, whilo8;
  logic [31:0] hi2, lo2, hi8, lo8;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .arith_stall(stall2), .busy(busy2), .hi_out(hi2), .lo_out(lo2), .whilo_out(whilo2));

  muldiv_ctrl #(.MUL_LAT(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .arith_stall(stall8), .busy(busy8), .hi_out(hi8), .lo_out(lo8), .whilo_out(whilo8));

  // Observed instance select
  bit          use8 = 1'b0;
  int          cur_lat = 2;
  logic        s_stall, s_busy, s_whilo;
  logic [31:0] s_hi, s_lo;
  always_comb begin
    s_stall = use8 ? stall8 : stall2;
    s_busy  = use8 ? busy8  : busy2;
    s_whilo = use8 ? whilo8 : whilo2;
    s_hi    = use8 ? hi8    : hi2;
    s_lo    = use8 ? lo8    : lo2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural operation.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;   // truncating, remainder follows dividend
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return cur_lat + 1;
    if (b == 0) return 1;
    return 33;
  endfunction

  // Issue one op, measure stall window and completion cycle, check results and hold.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int elat);
    logic [31:0] ph, pl;
    int done_at, stall_n;
    bit held;
    @(negedge clk);
    ph = s_hi; pl = s_lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    stall_n = s_stall ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = 0;
    held = 1'b1;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      if (s_whilo) done_at = k;
      else begin
        if (s_stall) stall_n++;
        if (s_hi !== ph || s_lo !== pl) held = 1'b0;
      end
    end
    chk({nm, " done_cycle"}, 64'(done_at), 64'(elat));
    chk({nm, " stall_cycles"}, 64'(stall_n), 64'(elat));
    chk({nm, " hold_while_busy"}, 64'(held), 64'd1);
    chk({nm, " hi"}, 64'(s_hi), 64'(ehi));
    chk({nm, " lo"}, 64'(s_lo), 64'(elo));
    chk({nm, " done_stall_busy"}, {62'h0, s_stall, s_busy}, 64'd0);
    @(negedge clk);
    chk({nm, " whilo_one_cycle"}, 64'(s_whilo), 64'd0);
    chk({nm, " hilo_after"}, {s_hi, s_lo}, {ehi, elo});
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  o;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] r;
  logic [31:0] ph, pl, ra, rb;
  logic [1:0]  ro;
  bit          pulse;

  initial begin
    vecs[0] = '{"mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3};
    vecs[1] = '{"multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
    vecs[2] = '{"divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33};
    vecs[3] = '{"div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4] = '{"div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33};
    vecs[5] = '{"divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1};
    vecs[6] = '{"div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33};
    vecs[7] = '{"div_by0", 2'd2, 32'h10, 32'd0, 32'h10, 32'hFFFF_FFFF, 1};

    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = 32'h0; src_b = 32'h0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {hi2, lo2}, 64'h0);
    chk("reset_flags", {60'h0, whilo2, busy2, stall2, whilo8}, 64'h0);

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Flush at T+10 of a divide: no write, results kept, next start completes.
    ph = s_hi; pl = s_lo; pulse = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (s_whilo) pulse = 1'b1;
      @(posedge clk);
    end
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_in_div", 64'(s_stall), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    if (s_whilo) pulse = 1'b1;
    chk("flush_idle", {62'h0, s_busy, s_stall}, 64'd0);
    chk("flush_no_whilo", 64'(pulse), 64'd0);
    chk("flush_hilo_kept", {s_hi, s_lo}, {ph, pl});
    @(posedge clk);
    run_op("after_flush", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 33);

    // Flush wins over a simultaneous start.
    ph = s_hi; pl = s_lo; pulse = 1'b0;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'd5;
    #1 chk("flush_start_stall", 64'(s_stall), 64'd0);
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    repeat (5) begin
      @(negedge clk);
      if (s_whilo || s_busy) pulse = 1'b1;
    end
    chk("flush_start_ignored", 64'(pulse), 64'd0);
    chk("flush_start_hilo", {s_hi, s_lo}, {ph, pl});

    // Random operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'h0;
      if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      r = ref_res(ro, ra, rb);
      run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, r[63:32], r[31:0], ref_lat(ro, rb));
    end

    // MUL_LAT=8 instance: resynchronise, produce a nonzero result, then reset mid-multiply.
    use8 = 1'b1; cur_lat = 8;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    run_op("mult_lat8", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 9);
    pulse = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (s_whilo) pulse = 1'b1;
      @(posedge clk);
    end
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_hilo", {s_hi, s_lo}, 64'h0);
    chk("rst_mid_flags", {61'h0, s_whilo, s_busy, s_stall}, 64'd0);
    repeat (12) begin
      @(negedge clk);
      if (s_whilo) pulse = 1'b1;
    end
    chk("rst_mid_no_whilo", 64'(pulse), 64'd0);
    run_op("after_reset", 2'd1, 32'd7, 32'd9, 32'd0, 32'd63, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
